z80_block_xfer_seq: RTL and testbench

- Execution sequencer for the Z80 block-transfer group LDI, LDD, LDIR and LDDR.
- The decoder hands it the opcode class and the current register values on a start pulse.
- It runs one memory read cycle (at HL) and one memory write cycle (at DE), then produces the updated BC/DE/HL/F/IP.
- It sits beside the main execute FSM, which stalls while busy=1.

---
 rtl/z80_block_xfer_seq_if.sv | 34 +++
 rtl/z80_block_xfer_seq.sv | 168 ++++++++++++++++
 tb/tb_z80_block_xfer_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/z80_block_xfer_seq_if.sv
// Memory bus between the block-transfer sequencer and the memory system.
// The sequencer is master; one read and one write channel, each ack-based.
interface z80_block_xfer_seq_if;
    logic        mem_rd;
    logic [15:0] mem_raddr;
    logic        mem_rack;
    logic [7:0]  mem_rdata;
    logic        mem_wr;
    logic [15:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic        mem_wack;

    modport master (
        output mem_rd,
        output mem_raddr,
        input  mem_rack,
        input  mem_rdata,
        output mem_wr,
        output mem_waddr,
        output mem_wdata,
        input  mem_wack
    );

    modport slave (
        input  mem_rd,
        input  mem_raddr,
        output mem_rack,
        output mem_rdata,
        input  mem_wr,
        input  mem_waddr,
        input  mem_wdata,
        output mem_wack
    );
endinterface

// File: rtl/z80_block_xfer_seq.sv
// Z80 LDI/LDD/LDIR/LDDR sequencer: one read at HL, one write at DE, reg update.
// Optional macro Z80_BLOCKXFER_UNDOC_FLAGS_EN derives F5/F3 from (byte + A).
module z80_block_xfer_seq #(
    parameter int RPT_EXTRA_CYCLES = 5
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [1:0]                  opcode,
    input  logic [15:0]                 reg_bc_in,
    input  logic [15:0]                 reg_de_in,
    input  logic [15:0]                 reg_hl_in,
    input  logic [15:0]                 reg_ip_in,
    input  logic [7:0]                  reg_a_in,
    input  logic [7:0]                  reg_f_in,
    z80_block_xfer_seq_if.master        mem,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 reg_bc_out,
    output logic [15:0]                 reg_de_out,
    output logic [15:0]                 reg_hl_out,
    output logic [15:0]                 reg_ip_out,
    output logic [7:0]                  reg_f_out
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_UPD  = 3'd3;
    localparam logic [2:0] S_RPT  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam bit RPT_EN = (RPT_EXTRA_CYCLES > 0);
    localparam logic [15:0] CNT_INIT =
        RPT_EN ? 16'(RPT_EXTRA_CYCLES - 1) : 16'd0;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [1:0]  op_q;
    logic [15:0] bc_q;
    logic [15:0] de_q;
    logic [15:0] hl_q;
    logic [15:0] ip_q;
    logic [7:0]  a_q;
    logic [7:0]  f_q;
    logic [7:0]  data_q;
    logic [15:0] cnt;

    logic [15:0] bc_dec;
    logic [15:0] de_nxt;
    logic [15:0] hl_nxt;
    logic [15:0] ip_nxt;
    logic [7:0]  f_nxt;
    logic [7:0]  n;
    logic        f5;
    logic        f3;
    logic        bc_nz;
    logic        again;
    logic        unused_bits;

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign mem.mem_rd    = (state == S_RD);
    assign mem.mem_wr    = (state == S_WR);
    assign mem.mem_raddr = hl_q;
    assign mem.mem_waddr = de_q;
    assign mem.mem_wdata = data_q;

    // Result datapath: counter decrement, pointer step, flags and IP.
    always_comb begin
        bc_dec = bc_q - 16'd1;
        bc_nz  = (bc_dec != 16'd0);
        again  = op_q[1] && bc_nz;
        de_nxt = op_q[0] ? (de_q - 16'd1) : (de_q + 16'd1);
        hl_nxt = op_q[0] ? (hl_q - 16'd1) : (hl_q + 16'd1);
        ip_nxt = again ? ip_q : (ip_q + 16'd2);
        n      = data_q + a_q;
`ifdef Z80_BLOCKXFER_UNDOC_FLAGS_EN
        f5     = n[1];
        f3     = n[3];
`else
        f5     = f_q[5];
        f3     = f_q[3];
`endif
        f_nxt  = {f_q[7], f_q[6], f5, 1'b0, f3, bc_nz, 1'b0, f_q[0]};
    end

    assign unused_bits = ^{n, f_q[5:1]};

    // Next-state decode for the transfer sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RD;
            S_RD:   if (mem.mem_rack) state_nxt = S_WR;
            S_WR:   if (mem.mem_wack) state_nxt = S_UPD;
            S_UPD:  state_nxt = (again && RPT_EN) ? S_RPT : S_DONE;
            S_RPT:  if (cnt == 16'd0) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch on start and read-data capture on the read ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= 2'd0;
            bc_q   <= 16'd0;
            de_q   <= 16'd0;
            hl_q   <= 16'd0;
            ip_q   <= 16'd0;
            a_q    <= 8'd0;
            f_q    <= 8'd0;
            data_q <= 8'd0;
        end else begin
            if (state == S_IDLE && start) begin
                op_q <= opcode;
                bc_q <= reg_bc_in;
                de_q <= reg_de_in;
                hl_q <= reg_hl_in;
                ip_q <= reg_ip_in;
                a_q  <= reg_a_in;
                f_q  <= reg_f_in;
            end
            if (state == S_RD && mem.mem_rack) begin
                data_q <= mem.mem_rdata;
            end
        end
    end

    // Result registers; they hold until the next update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_bc_out <= 16'd0;
            reg_de_out <= 16'd0;
            reg_hl_out <= 16'd0;
            reg_ip_out <= 16'd0;
            reg_f_out  <= 8'd0;
        end else if (state == S_UPD) begin
            reg_bc_out <= bc_dec;
            reg_de_out <= de_nxt;
            reg_hl_out <= hl_nxt;
            reg_ip_out <= ip_nxt;
            reg_f_out  <= f_nxt;
        end
    end

    // Extra idle cycles after a repeating iteration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 16'd0;
        end else if (state == S_UPD) begin
            cnt <= CNT_INIT;
        end else if (state == S_RPT && cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
        end
    end

endmodule

// File: tb/tb_z80_block_xfer_seq.sv
// Directed bench for z80_block_xfer_seq: vector table plus
// hand-written reset-during-write and reset-state sequences.
module tb_z80_block_xfer_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  opcode = 2'd0;
    logic [15:0] bc_in = '0, de_in = '0, hl_in = '0, ip_in = '0;
    logic [7:0]  a_in = '0, f_in = '0;
    logic        busy, done;
    logic [15:0] bc_out, de_out, hl_out, ip_out;
    logic [7:0]  f_out;

    z80_block_xfer_seq_if mem_bus();

    z80_block_xfer_seq #(.RPT_EXTRA_CYCLES(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .opcode     (opcode),
        .reg_bc_in  (bc_in),
        .reg_de_in  (de_in),
        .reg_hl_in  (hl_in),
        .reg_ip_in  (ip_in),
        .reg_a_in   (a_in),
        .reg_f_in   (f_in),
        .mem        (mem_bus),
        .busy       (busy),
        .done       (done),
        .reg_bc_out (bc_out),
        .reg_de_out (de_out),
        .reg_hl_out (hl_out),
        .reg_ip_out (ip_out),
        .reg_f_out  (f_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] bc, de, hl, ip;
        logic [7:0]  a, f, rdata;
        int          rwait, wwait;
        bit          noise;
        logic [15:0] xbc, xde, xhl, xip;
        logic [7:0]  xf;
        int          xlat;
    } vec_t;

    vec_t vecs[7];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xflag(input vec_t v);
`ifdef Z80_BLOCKXFER_UNDOC_FLAGS_EN
        logic [7:0] s;
        s = v.rdata + v.a;
        return (v.xf & 8'hD7) | {2'b00, s[1], 1'b0, s[3], 3'b000};
`else
        return v.xf;
`endif
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int cyc, rdc, wrc;
        bit seen, both;
        logic [15:0] ra, wa;
        logic [7:0] wd;
        ra = v.hl; wa = v.de; wd = v.rdata;
        rdc = 0; wrc = 0; both = 0; seen = 0;
        start = 1'b1; opcode = v.op;
        bc_in = v.bc; de_in = v.de; hl_in = v.hl; ip_in = v.ip;
        a_in = v.a; f_in = v.f;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!seen && cyc < 100) begin
            mem_bus.mem_rack = 1'b0;
            mem_bus.mem_wack = 1'b0;
            mem_bus.mem_rdata = 8'hEE;
            if (v.noise) begin
                start = 1'b1; opcode = 2'b11;
                bc_in = 16'hDEAD; de_in = 16'hBEEF; hl_in = 16'h7777;
                ip_in = 16'h4242; a_in = 8'h55; f_in = 8'hAA;
            end
            if (mem_bus.mem_rd && mem_bus.mem_wr) both = 1'b1;
            if (mem_bus.mem_rd) begin
                if (mem_bus.mem_raddr !== v.hl) ra = mem_bus.mem_raddr;
                if (rdc == v.rwait) begin
                    mem_bus.mem_rack = 1'b1;
                    mem_bus.mem_rdata = v.rdata;
                end
                rdc++;
            end
            if (mem_bus.mem_wr) begin
                if (mem_bus.mem_waddr !== v.de) wa = mem_bus.mem_waddr;
                if (mem_bus.mem_wdata !== v.rdata) wd = mem_bus.mem_wdata;
                if (wrc == v.wwait) mem_bus.mem_wack = 1'b1;
                wrc++;
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                tick();
                cyc++;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(v.xlat));
        chk({tag, "_rd_cycles"}, 32'(rdc), 32'(v.rwait + 1));
        chk({tag, "_wr_cycles"}, 32'(wrc), 32'(v.wwait + 1));
        chk({tag, "_raddr"}, 32'(ra), 32'(v.hl));
        chk({tag, "_waddr"}, 32'(wa), 32'(v.de));
        chk({tag, "_wdata"}, 32'(wd), 32'(v.rdata));
        chk({tag, "_rd_wr_excl"}, 32'(both), 32'd0);
        chk({tag, "_bc"}, 32'(bc_out), 32'(v.xbc));
        chk({tag, "_de"}, 32'(de_out), 32'(v.xde));
        chk({tag, "_hl"}, 32'(hl_out), 32'(v.xhl));
        chk({tag, "_ip"}, 32'(ip_out), 32'(v.xip));
        chk({tag, "_f"}, 32'(f_out), 32'(xflag(v)));
        mem_bus.mem_rack = 1'b0;
        mem_bus.mem_wack = 1'b0;
        tick();
        start = 1'b0;
        chk({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_hold_bc"}, 32'(bc_out), 32'(v.xbc));
    endtask

    initial begin
        bit bad;
        mem_bus.mem_rack = 1'b0;
        mem_bus.mem_wack = 1'b0;
        mem_bus.mem_rdata = 8'h00;

        // op, bc, de, hl, ip, a, f, rdata, rwait, wwait, noise,
        // xbc, xde, xhl, xip, xf, xlat
        vecs[0] = '{2'b01, 16'h0005, 16'h3000, 16'h2000, 16'h0100,
                    8'h00, 8'hFF, 8'h5A, 0, 0, 1'b0,
                    16'h0004, 16'h2FFF, 16'h1FFF, 16'h0102, 8'hED, 4};
        vecs[1] = '{2'b00, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000,
                    8'h00, 8'h00, 8'h11, 0, 0, 1'b0,
                    16'h0000, 16'h0000, 16'h0000, 16'h0002, 8'h00, 4};
        vecs[2] = '{2'b10, 16'h0002, 16'h5000, 16'h4000, 16'h0200,
                    8'h00, 8'h00, 8'h33, 0, 0, 1'b0,
                    16'h0001, 16'h5001, 16'h4001, 16'h0200, 8'h04, 9};
        vecs[3] = '{2'b10, 16'h0001, 16'h5001, 16'h4001, 16'h0200,
                    8'h00, 8'h00, 8'h34, 0, 0, 1'b0,
                    16'h0000, 16'h5002, 16'h4002, 16'h0202, 8'h00, 4};
        vecs[4] = '{2'b11, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF,
                    8'h00, 8'hC1, 8'h77, 0, 0, 1'b0,
                    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hC5, 9};
        vecs[5] = '{2'b00, 16'h0010, 16'h5678, 16'h1234, 16'h0300,
                    8'h00, 8'h28, 8'h9C, 3, 2, 1'b1,
                    16'h000F, 16'h5679, 16'h1235, 16'h0302, 8'h2C, 9};
        vecs[6] = '{2'b00, 16'h0001, 16'h0200, 16'h0100, 16'h0010,
                    8'h10, 8'h00, 8'h2A, 0, 0, 1'b0,
                    16'h0000, 16'h0201, 16'h0101, 16'h0012, 8'h00, 4};

        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd", 32'(mem_bus.mem_rd), 32'd0);
        chk("rst_wr", 32'(mem_bus.mem_wr), 32'd0);
        chk("rst_raddr", 32'(mem_bus.mem_raddr), 32'd0);
        chk("rst_waddr", 32'(mem_bus.mem_waddr), 32'd0);
        chk("rst_wdata", 32'(mem_bus.mem_wdata), 32'd0);
        chk("rst_outs", {bc_out, de_out}, 32'd0);
        chk("rst_outs2", {hl_out, ip_out}, 32'd0);
        chk("rst_f", 32'(f_out), 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        start = 1'b1; opcode = 2'b00;
        bc_in = 16'h0003; de_in = 16'h0A00; hl_in = 16'h0B00;
        ip_in = 16'h0040; a_in = 8'h00; f_in = 8'h00;
        tick();
        start = 1'b0;
        chk("mid_rd", 32'(mem_bus.mem_rd), 32'd1);
        mem_bus.mem_rack = 1'b1;
        mem_bus.mem_rdata = 8'h66;
        tick();
        mem_bus.mem_rack = 1'b0;
        chk("mid_wr", 32'(mem_bus.mem_wr), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_wr", 32'(mem_bus.mem_wr), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_waddr", 32'(mem_bus.mem_waddr), 32'd0);
        chk("mid_rst_bc", 32'(bc_out), 32'd0);
        tick();
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) bad = 1'b1;
        end
        chk("mid_rst_quiet", 32'(bad), 32'd0);
        run_vec(vecs[0], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
